issue_hazard_ctrl: RTL and testbench



---
 rtl/issue_hazard_ctrl.sv | 89 ++++++++
 tb/tb_issue_hazard_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: issue/dispatch stall, flush and branch-count control; perf counters under HAZARD_PERF_CNT_EN.
module issue_hazard_ctrl #(
  parameter int NUM_FU          = 3,
  parameter int MAX_BR_INFLIGHT = 2,
  parameter int FLUSH_HOLD      = 2,
  parameter int PERF_W          = 32,
  localparam int BW             = $clog2(MAX_BR_INFLIGHT + 1),
  localparam int FW             = $clog2(FLUSH_HOLD + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              is_valid_inst,
  input  logic [NUM_FU-1:0] fu_sel,
  input  logic              is_branch,
  input  logic [NUM_FU-1:0] rs_full,
  input  logic              rob_full,
  input  logic              br_resolve,
  input  logic              branch_misprediction,
  input  logic              commit_wr_mem,
  input  logic              lb_read_mem,
  input  logic [NUM_FU-1:0] fu_wr_valid,
  input  logic [NUM_FU-1:0] fu_wr_written,
  output logic              rob_enable,
  output logic [NUM_FU-1:0] rs_enable,
  output logic              if_enable,
  output logic              if_is_enable,
  output logic              if_is_flush,
  output logic [NUM_FU-1:0] fu_wr_enable,
  output logic [NUM_FU-1:0] fu_exec_stall,
  output logic [BW-1:0]     br_inflight,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flush_cycles,
  output logic [PERF_W-1:0] perf_mispredicts
);
  logic [BW-1:0] br_q, br_d;
  logic [FW-1:0] flush_q, flush_d;
  logic mem_hazard, sel_ok, flush_busy, is_stall, is_enable, inc;
  assign mem_hazard    = commit_wr_mem | lb_read_mem;
  assign sel_ok        = (fu_sel != '0) && ((fu_sel & (fu_sel - NUM_FU'(1))) == '0);
  assign flush_busy    = flush_q != '0;
  assign is_stall      = rob_full | (|(fu_sel & rs_full)) | (br_q == BW'(MAX_BR_INFLIGHT)) | flush_busy;
  assign is_enable     = ~reset & ~is_stall & is_valid_inst & sel_ok & ~branch_misprediction;
  assign rob_enable    = is_enable;
  assign rs_enable     = is_enable ? fu_sel : '0;
  assign if_enable     = ~reset & ~(mem_hazard | is_stall);
  assign if_is_enable  = ~reset & ~is_stall;
  assign if_is_flush   = reset | branch_misprediction | flush_busy | (mem_hazard & ~is_stall);
  assign fu_wr_enable  = reset ? '1 : (~fu_wr_valid | fu_wr_written);
  assign fu_exec_stall = ~fu_wr_enable;
  assign br_inflight   = br_q;
  assign inc           = is_branch & is_enable;
  always_comb begin
    br_d    = branch_misprediction ? '0 :
              (inc & ~br_resolve) ? br_q + BW'(1) :
              (br_resolve & ~inc & br_q != '0) ? br_q - BW'(1) : br_q;
    flush_d = branch_misprediction ? FW'(FLUSH_HOLD - 1) :
              flush_busy ? flush_q - FW'(1) : flush_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      br_q    <= '0;
      flush_q <= '0;
    end else begin
      br_q    <= br_d;
      flush_q <= flush_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, flushc_q, mispred_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q   <= '0;
      flushc_q  <= '0;
      mispred_q <= '0;
    end else begin
      stall_q   <= stall_q + PERF_W'(is_valid_inst & is_stall);
      flushc_q  <= flushc_q + PERF_W'(if_is_flush);
      mispred_q <= mispred_q + PERF_W'(branch_misprediction);
    end
  end
  assign perf_stall_cycles = stall_q;
  assign perf_flush_cycles = flushc_q;
  assign perf_mispredicts  = mispred_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_cycles = '0;
  assign perf_mispredicts  = '0;
`endif
endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb_issue_hazard_ctrl: directed checks of dispatch, stall, flush shadow, branch count and perf counters.
module tb_issue_hazard_ctrl;
  logic clock, reset, is_valid_inst, is_branch, rob_full, br_resolve;
  logic branch_misprediction, commit_wr_mem, lb_read_mem;
  logic [2:0] fu_sel, rs_full, fu_wr_valid, fu_wr_written;
  logic rob_enable, if_enable, if_is_enable, if_is_flush;
  logic [2:0] rs_enable, fu_wr_enable, fu_exec_stall;
  logic [1:0] br_inflight;
  logic [31:0] perf_stall_cycles, perf_flush_cycles, perf_mispredicts;
  int total = 0, bad = 0;

  issue_hazard_ctrl dut (
    .clock(clock), .reset(reset), .is_valid_inst(is_valid_inst), .fu_sel(fu_sel),
    .is_branch(is_branch), .rs_full(rs_full), .rob_full(rob_full), .br_resolve(br_resolve),
    .branch_misprediction(branch_misprediction), .commit_wr_mem(commit_wr_mem),
    .lb_read_mem(lb_read_mem), .fu_wr_valid(fu_wr_valid), .fu_wr_written(fu_wr_written),
    .rob_enable(rob_enable), .rs_enable(rs_enable), .if_enable(if_enable),
    .if_is_enable(if_is_enable), .if_is_flush(if_is_flush), .fu_wr_enable(fu_wr_enable),
    .fu_exec_stall(fu_exec_stall), .br_inflight(br_inflight),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_cycles(perf_flush_cycles),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr;
    is_valid_inst = 0; is_branch = 0; rob_full = 0; br_resolve = 0;
    branch_misprediction = 0; commit_wr_mem = 0; lb_read_mem = 0;
    fu_sel = 0; rs_full = 0; fu_wr_valid = 0; fu_wr_written = 0;
  endtask

  initial begin
    clock = 0; reset = 1; clr(); is_valid_inst = 1; fu_sel = 3'b010;
    tick; #1;
    chk("rst_rob", rob_enable, 0);
    chk("rst_rs", rs_enable, 0);
    chk("rst_if", if_enable, 0);
    chk("rst_ifis", if_is_enable, 0);
    chk("rst_flush", if_is_flush, 1);
    chk("rst_wren", fu_wr_enable, 3'b111);
    chk("rst_xstall", fu_exec_stall, 0);
    chk("rst_br", br_inflight, 0);
    chk("rst_perf", {perf_stall_cycles, perf_flush_cycles}, 0);
    chk("rst_perf_mp", perf_mispredicts, 0);
    reset = 0; #1;
    chk("alu_rs", rs_enable, 3'b010);
    chk("alu_rob", rob_enable, 1);
    chk("alu_if", if_enable, 1);
    chk("alu_flush", if_is_flush, 0);
    tick;
    fu_sel = 3'b011; #1;
    chk("sel_bad_rob", rob_enable, 0);
    chk("sel_bad_rs", rs_enable, 0);
    chk("sel_bad_if", if_enable, 1);
    tick;
    fu_sel = 3'b001; is_branch = 1; #1;
    chk("br1_rob", rob_enable, 1);
    chk("br1_rs", rs_enable, 3'b001);
    tick; #1;
    chk("br_cnt1", br_inflight, 1);
    chk("br2_rob", rob_enable, 1);
    tick; #1;
    chk("br_cnt2", br_inflight, 2);
    chk("brmax_rob", rob_enable, 0);
    chk("brmax_rs", rs_enable, 0);
    chk("brmax_ifis", if_is_enable, 0);
    chk("brmax_if", if_enable, 0);
    is_branch = 0; br_resolve = 1; #1;
    chk("resolve_same_rob", rob_enable, 0);
    tick; br_resolve = 0; #1;
    chk("resolve_cnt", br_inflight, 1);
    chk("resolve_rob", rob_enable, 1);
    is_branch = 1; br_resolve = 1;
    tick; is_branch = 0; br_resolve = 0; #1;
    chk("incdec_cnt", br_inflight, 1);
    is_branch = 1;
    tick; is_branch = 0; branch_misprediction = 1; #1;
    chk("mp_cnt_before", br_inflight, 2);
    chk("mp_flush0", if_is_flush, 1);
    chk("mp_rob0", rob_enable, 0);
    tick; branch_misprediction = 0; #1;
    chk("mp_cnt_clr", br_inflight, 0);
    chk("mp_flush1", if_is_flush, 1);
    chk("mp_rob1", rob_enable, 0);
    tick; #1;
    chk("mp_flush2", if_is_flush, 0);
    chk("mp_rob2", rob_enable, 1);
    branch_misprediction = 1; #1;
    chk("mp2_flush0", if_is_flush, 1);
    tick; #1;
    chk("mp2_flush1", if_is_flush, 1);
    tick; branch_misprediction = 0; #1;
    chk("mp2_flush2", if_is_flush, 1);
    chk("mp2_rob2", rob_enable, 0);
    tick; #1;
    chk("mp2_flush3", if_is_flush, 0);
    chk("mp2_rob3", rob_enable, 1);
    is_valid_inst = 0; br_resolve = 1;
    tick; br_resolve = 0; #1;
    chk("dec_sat0", br_inflight, 0);
    clr(); fu_wr_valid = 3'b100; #1;
    chk("wb_stall", fu_exec_stall, 3'b100);
    chk("wb_en", fu_wr_enable, 3'b011);
    fu_wr_written = 3'b100; #1;
    chk("wb_written", fu_exec_stall, 0);
    clr(); commit_wr_mem = 1; #1;
    chk("mem_if", if_enable, 0);
    chk("mem_flush", if_is_flush, 1);
    chk("mem_ifis", if_is_enable, 1);
    rob_full = 1; #1;
    chk("memrob_flush", if_is_flush, 0);
    chk("memrob_ifis", if_is_enable, 0);
    chk("memrob_if", if_enable, 0);
    clr(); lb_read_mem = 1; #1;
    chk("lb_if", if_enable, 0);
    clr(); is_valid_inst = 1; fu_sel = 3'b010; rs_full = 3'b010; #1;
    chk("rsfull_rob", rob_enable, 0);
    rs_full = 3'b100; #1;
    chk("rsother_rs", rs_enable, 3'b010);
    clr(); is_valid_inst = 1; fu_sel = 3'b001; is_branch = 1;
    tick; clr(); reset = 1; #1;
    chk("rstmid_br_before", br_inflight, 1);
    tick; reset = 0; #1;
    chk("rstmid_br", br_inflight, 0);
    branch_misprediction = 1;
    tick; branch_misprediction = 0; reset = 1;
    tick; reset = 0; #1;
    chk("rstmid_flush", if_is_flush, 0);
    chk("rstmid_ifis", if_is_enable, 1);
    reset = 1;
    tick; reset = 0; is_valid_inst = 1; fu_sel = 3'b001; rob_full = 1;
    repeat (5) tick;
    clr(); branch_misprediction = 1;
    tick; branch_misprediction = 0;
    tick; tick; #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, 5);
    chk("perf_flush", perf_flush_cycles, 2);
    chk("perf_mp", perf_mispredicts, 1);
`else
    chk("perf_stall", perf_stall_cycles, 0);
    chk("perf_flush", perf_flush_cycles, 0);
    chk("perf_mp", perf_mispredicts, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
